// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-through, no-write-allocate data cache
// controller with 8-byte blocks, sitting directly downstream of the LSQ.
//
// Ports:
//   clock, reset            clock, asynchronous active-low reset
//   lsq_rd_mem/addr/pr/ar   load request from the LSQ (one per cycle)
//   Dcache_avail            load will be accepted (a free MSHR exists)
//   lsq_st_valid/addr/value retired store at the LSQ head
//   st_ack                  store accepted, LSQ pops its head
//   cdb_* / prf_pr_*        load result on the memory CDB slot and PRF port
//   proc2mem_*              single-port tagged memory request
//   mem2proc_*              issue tag (0 = rejected), completion tag and data
module dcache_ctrl #(
  parameter int NUM_LINES  = 32,
  parameter int IDX_BITS   = 5,
  parameter int MSHR_DEPTH = 4,
  parameter int MSHR_BITS  = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        lsq_rd_mem,
  input  logic [63:0] lsq_addr,
  input  logic [6:0]  lsq_pr_idx,
  input  logic [4:0]  lsq_ar_idx,
  output logic        Dcache_avail,
  input  logic        lsq_st_valid,
  input  logic [63:0] lsq_st_addr,
  input  logic [63:0] lsq_st_value,
  output logic        st_ack,
  output logic        cdb_complete,
  output logic [6:0]  cdb_prf_pr_idx,
  output logic [4:0]  cdb_ar_idx,
  output logic        prf_pr_wr_enable,
  output logic [63:0] prf_pr_value,
  output logic [1:0]  proc2mem_command,
  output logic [63:0] proc2mem_addr,
  output logic [63:0] proc2mem_data,
  input  logic [3:0]  mem2proc_response,
  input  logic [63:0] mem2proc_data,
  input  logic [3:0]  mem2proc_tag
);

  localparam int TAG_BITS = 64 - IDX_BITS - 3;

  typedef enum logic [1:0] {FREE, WAIT_SEND, WAIT_RESP, DONE} mshr_state_e;

  // Line storage
  logic                line_valid_q [NUM_LINES];
  logic [TAG_BITS-1:0] line_tag_q   [NUM_LINES];
  logic [63:0]         line_data_q  [NUM_LINES];

  // MSHR file; addresses are kept as block addresses (addr[63:3])
  mshr_state_e state_q [MSHR_DEPTH];
  mshr_state_e state_d [MSHR_DEPTH];
  logic [60:0] m_addr_q [MSHR_DEPTH];
  logic [6:0]  m_pr_q   [MSHR_DEPTH];
  logic [4:0]  m_ar_q   [MSHR_DEPTH];
  logic [3:0]  m_tag_q  [MSHR_DEPTH];
  logic [63:0] m_data_q [MSHR_DEPTH];
  logic [MSHR_DEPTH-1:0] alloc_en, issue_en, fill_en;

  // Single-entry store buffer and the load-hit result register
  logic        sb_valid_q;
  logic [60:0] sb_addr_q;
  logic [63:0] sb_data_q;
  logic        hit_valid_q;
  logic [63:0] hit_data_q;
  logic [6:0]  hit_pr_q;
  logic [4:0]  hit_ar_q;

  logic [IDX_BITS-1:0] ld_idx, st_idx;
  logic                ld_hit, st_hit, ld_accept, ld_miss_alloc;
  logic                any_free, any_send, any_done, st_conflict;
  logic [MSHR_BITS-1:0] alloc_idx, send_idx, done_idx;
  logic                mem_accepted, issue_load, sb_drain, take_done;
  logic                unused_addr_bits;

  assign unused_addr_bits = ^{lsq_addr[2:0], lsq_st_addr[2:0]};

  // Lookups read the arrays before any write of this cycle lands
  assign ld_idx = lsq_addr[IDX_BITS+2:3];
  assign st_idx = lsq_st_addr[IDX_BITS+2:3];
  assign ld_hit = line_valid_q[ld_idx] && (line_tag_q[ld_idx] == lsq_addr[63:IDX_BITS+3]);
  assign st_hit = line_valid_q[st_idx] && (line_tag_q[st_idx] == lsq_st_addr[63:IDX_BITS+3]);

  // Lowest-index search over the MSHR file for allocation, issue and CDB
  // grant; also flag any live miss to the store's block, which must hold
  // the store back so a later fill cannot overwrite newer store data.
  always_comb begin
    any_free    = 1'b0;
    any_send    = 1'b0;
    any_done    = 1'b0;
    st_conflict = 1'b0;
    alloc_idx   = '0;
    send_idx    = '0;
    done_idx    = '0;
    for (int i = MSHR_DEPTH - 1; i >= 0; i--) begin
      if (state_q[i] == FREE)      begin any_free = 1'b1; alloc_idx = MSHR_BITS'(i); end
      if (state_q[i] == WAIT_SEND) begin any_send = 1'b1; send_idx  = MSHR_BITS'(i); end
      if (state_q[i] == DONE)      begin any_done = 1'b1; done_idx  = MSHR_BITS'(i); end
      if (state_q[i] != FREE && m_addr_q[i] == lsq_st_addr[63:3]) st_conflict = 1'b1;
    end
  end

  assign Dcache_avail  = reset & any_free;
  assign ld_accept     = lsq_rd_mem & Dcache_avail;
  assign ld_miss_alloc = ld_accept & ~ld_hit;
  assign mem_accepted  = (mem2proc_response != 4'd0);
  assign issue_load    = ~sb_valid_q & any_send;
  assign sb_drain      = sb_valid_q & mem_accepted;
  assign take_done     = ~hit_valid_q & any_done;
  assign st_ack        = reset & lsq_st_valid & (~sb_valid_q | sb_drain) & ~st_conflict;

  // MSHR entry next-state logic; the enables tell the register process
  // which payload fields to capture on each transition.
  always_comb begin
    alloc_en = '0;
    issue_en = '0;
    fill_en  = '0;
    for (int i = 0; i < MSHR_DEPTH; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        FREE:
          if (ld_miss_alloc && alloc_idx == MSHR_BITS'(i)) begin
            state_d[i]  = WAIT_SEND;
            alloc_en[i] = 1'b1;
          end
        WAIT_SEND:
          if (issue_load && send_idx == MSHR_BITS'(i) && mem_accepted) begin
            state_d[i]  = WAIT_RESP;
            issue_en[i] = 1'b1;
          end
        WAIT_RESP:
          if (mem2proc_tag != 4'd0 && mem2proc_tag == m_tag_q[i]) begin
            state_d[i] = DONE;
            fill_en[i] = 1'b1;
          end
        DONE:
          if (take_done && done_idx == MSHR_BITS'(i)) state_d[i] = FREE;
        default: state_d[i] = FREE;
      endcase
    end
  end

  // MSHR state and payload registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MSHR_DEPTH; i++) begin
        state_q[i]  <= FREE;
        m_addr_q[i] <= '0;
        m_pr_q[i]   <= '0;
        m_ar_q[i]   <= '0;
        m_tag_q[i]  <= '0;
        m_data_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < MSHR_DEPTH; i++) begin
        state_q[i] <= state_d[i];
        if (alloc_en[i]) begin
          m_addr_q[i] <= lsq_addr[63:3];
          m_pr_q[i]   <= lsq_pr_idx;
          m_ar_q[i]   <= lsq_ar_idx;
        end
        if (issue_en[i]) m_tag_q[i]  <= mem2proc_response;
        if (fill_en[i])  m_data_q[i] <= mem2proc_data;
      end
    end
  end

  // Line valid bits: only fills set them, only reset clears them
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int l = 0; l < NUM_LINES; l++) line_valid_q[l] <= 1'b0;
    end else begin
      for (int i = 0; i < MSHR_DEPTH; i++)
        if (fill_en[i]) line_valid_q[m_addr_q[i][IDX_BITS-1:0]] <= 1'b1;
    end
  end

  // Tag and data arrays; a store hit is written last so it wins over a
  // fill to the same index in the same cycle.
  always_ff @(posedge clock) begin
    for (int i = 0; i < MSHR_DEPTH; i++) begin
      if (fill_en[i]) begin
        line_tag_q[m_addr_q[i][IDX_BITS-1:0]]  <= m_addr_q[i][60:IDX_BITS];
        line_data_q[m_addr_q[i][IDX_BITS-1:0]] <= mem2proc_data;
      end
    end
    if (st_ack && st_hit) line_data_q[st_idx] <= lsq_st_value;
  end

  // Store buffer fills on accept and empties once memory takes the STORE
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sb_valid_q <= 1'b0;
      sb_addr_q  <= '0;
      sb_data_q  <= '0;
    end else if (st_ack) begin
      sb_valid_q <= 1'b1;
      sb_addr_q  <= lsq_st_addr[63:3];
      sb_data_q  <= lsq_st_value;
    end else if (sb_drain) begin
      sb_valid_q <= 1'b0;
    end
  end

  // Hit register; it always wins the CDB so it only ever holds one cycle
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hit_valid_q <= 1'b0;
      hit_data_q  <= '0;
      hit_pr_q    <= '0;
      hit_ar_q    <= '0;
    end else begin
      hit_valid_q <= ld_accept & ld_hit;
      if (ld_accept && ld_hit) begin
        hit_data_q <= line_data_q[ld_idx];
        hit_pr_q   <= lsq_pr_idx;
        hit_ar_q   <= lsq_ar_idx;
      end
    end
  end

  // Memory and CDB output muxes
  always_comb begin
    proc2mem_command = 2'd0;
    proc2mem_addr    = '0;
    proc2mem_data    = '0;
    if (sb_valid_q) begin
      proc2mem_command = 2'd2;
      proc2mem_addr    = {sb_addr_q, 3'b000};
      proc2mem_data    = sb_data_q;
    end else if (any_send) begin
      proc2mem_command = 2'd1;
      proc2mem_addr    = {m_addr_q[send_idx], 3'b000};
    end
    cdb_complete   = 1'b0;
    cdb_prf_pr_idx = '0;
    cdb_ar_idx     = '0;
    prf_pr_value   = '0;
    if (hit_valid_q) begin
      cdb_complete   = 1'b1;
      cdb_prf_pr_idx = hit_pr_q;
      cdb_ar_idx     = hit_ar_q;
      prf_pr_value   = hit_data_q;
    end else if (any_done) begin
      cdb_complete   = 1'b1;
      cdb_prf_pr_idx = m_pr_q[done_idx];
      cdb_ar_idx     = m_ar_q[done_idx];
      prf_pr_value   = m_data_q[done_idx];
    end
    prf_pr_wr_enable = cdb_complete;
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: directed self-checking bench for dcache_ctrl. Inputs are
// driven just after each falling edge and outputs checked 1 ns later.
module tb_dcache_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        lsq_rd_mem = 1'b0;
  logic [63:0] lsq_addr = '0;
  logic [6:0]  lsq_pr_idx = '0;
  logic [4:0]  lsq_ar_idx = '0;
  logic        Dcache_avail;
  logic        lsq_st_valid = 1'b0;
  logic [63:0] lsq_st_addr = '0;
  logic [63:0] lsq_st_value = '0;
  logic        st_ack;
  logic        cdb_complete;
  logic [6:0]  cdb_prf_pr_idx;
  logic [4:0]  cdb_ar_idx;
  logic        prf_pr_wr_enable;
  logic [63:0] prf_pr_value;
  logic [1:0]  proc2mem_command;
  logic [63:0] proc2mem_addr;
  logic [63:0] proc2mem_data;
  logic [3:0]  mem2proc_response = '0;
  logic [63:0] mem2proc_data = '0;
  logic [3:0]  mem2proc_tag = '0;

  int vectors = 0;
  int miscompares = 0;

  dcache_ctrl dut (
    .clock(clock), .reset(reset),
    .lsq_rd_mem(lsq_rd_mem), .lsq_addr(lsq_addr), .lsq_pr_idx(lsq_pr_idx),
    .lsq_ar_idx(lsq_ar_idx), .Dcache_avail(Dcache_avail),
    .lsq_st_valid(lsq_st_valid), .lsq_st_addr(lsq_st_addr),
    .lsq_st_value(lsq_st_value), .st_ack(st_ack),
    .cdb_complete(cdb_complete), .cdb_prf_pr_idx(cdb_prf_pr_idx),
    .cdb_ar_idx(cdb_ar_idx), .prf_pr_wr_enable(prf_pr_wr_enable),
    .prf_pr_value(prf_pr_value), .proc2mem_command(proc2mem_command),
    .proc2mem_addr(proc2mem_addr), .proc2mem_data(proc2mem_data),
    .mem2proc_response(mem2proc_response), .mem2proc_data(mem2proc_data),
    .mem2proc_tag(mem2proc_tag)
  );

  always #5 clock = ~clock;

  // Advance to the next falling edge, drive every input, let logic settle
  task automatic applyStimulus(input logic [63:0] rd, input logic [63:0] addr,
                               input logic [63:0] pr, input logic [63:0] ar,
                               input logic [63:0] stv, input logic [63:0] sta,
                               input logic [63:0] stval, input logic [63:0] resp,
                               input logic [63:0] tag, input logic [63:0] mdata);
    @(negedge clock);
    lsq_rd_mem        = rd[0];
    lsq_addr          = addr;
    lsq_pr_idx        = pr[6:0];
    lsq_ar_idx        = ar[4:0];
    lsq_st_valid      = stv[0];
    lsq_st_addr       = sta;
    lsq_st_value      = stval;
    mem2proc_response = resp[3:0];
    mem2proc_tag      = tag[3:0];
    mem2proc_data     = mdata;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] observed,
                             input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", name, observed, expected);
    end
  endtask

  initial begin
    // Reset held low with requests present: everything must stay quiet
    applyStimulus(1, 'h100, 12, 3, 1, 'h40, 1, 0, 5, 'hDEAD);
    checkOutput("rst_avail", Dcache_avail, 0);
    checkOutput("rst_st_ack", st_ack, 0);
    checkOutput("rst_cdb", cdb_complete, 0);
    checkOutput("rst_cmd", proc2mem_command, 0);
    checkOutput("rst_prf_we", prf_pr_wr_enable, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    #1;
    checkOutput("rel_avail", Dcache_avail, 1);

    $display("[TB] cold load of 0x100");
    applyStimulus(1, 'h100, 12, 3, 0, 0, 0, 0, 0, 0);
    checkOutput("cold_avail", Dcache_avail, 1);
    checkOutput("cold_cmd0", proc2mem_command, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 5, 0, 0);
    checkOutput("cold_cmd", proc2mem_command, 1);
    checkOutput("cold_addr", proc2mem_addr, 'h100);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("cold_cmd_idle", proc2mem_command, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 5, 'hDEAD);
    checkOutput("cold_cdb_early", cdb_complete, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("cold_cdb", cdb_complete, 1);
    checkOutput("cold_pr", cdb_prf_pr_idx, 12);
    checkOutput("cold_ar", cdb_ar_idx, 3);
    checkOutput("cold_value", prf_pr_value, 'hDEAD);
    checkOutput("cold_we", prf_pr_wr_enable, 1);
    applyStimulus(1, 'h100, 20, 4, 0, 0, 0, 0, 0, 0);
    checkOutput("reload_cdb_idle", cdb_complete, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("reload_cdb", cdb_complete, 1);
    checkOutput("reload_pr", cdb_prf_pr_idx, 20);
    checkOutput("reload_value", prf_pr_value, 'hDEAD);
    checkOutput("reload_no_miss", proc2mem_command, 0);

    $display("[TB] four outstanding misses");
    applyStimulus(1, 'h1008, 1, 1, 0, 0, 0, 0, 0, 0);
    checkOutput("m1_avail", Dcache_avail, 1);
    applyStimulus(1, 'h2010, 2, 2, 0, 0, 0, 0, 0, 0);
    checkOutput("m2_cmd", proc2mem_command, 1);
    checkOutput("m2_addr", proc2mem_addr, 'h1008);
    applyStimulus(1, 'h3018, 3, 3, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 'h4020, 4, 4, 0, 0, 0, 0, 0, 0);
    checkOutput("m4_avail", Dcache_avail, 1);
    applyStimulus(1, 'h5028, 5, 5, 0, 0, 0, 0, 0, 0);
    checkOutput("full_avail", Dcache_avail, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("iss1_addr", proc2mem_addr, 'h1008);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 2, 0, 0);
    checkOutput("iss2_addr", proc2mem_addr, 'h2010);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 3, 0, 0);
    checkOutput("iss3_addr", proc2mem_addr, 'h3018);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 4, 0, 0);
    checkOutput("iss4_cmd", proc2mem_command, 1);
    checkOutput("iss4_addr", proc2mem_addr, 'h4020);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("iss_done_cmd", proc2mem_command, 0);
    checkOutput("iss_done_avail", Dcache_avail, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 4, 'h44);
    checkOutput("t4_cdb_early", cdb_complete, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 2, 'h22);
    checkOutput("t4_pr", cdb_prf_pr_idx, 4);
    checkOutput("t4_value", prf_pr_value, 'h44);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 'h11);
    checkOutput("t2_pr", cdb_prf_pr_idx, 2);
    checkOutput("t2_value", prf_pr_value, 'h22);
    checkOutput("t2_avail", Dcache_avail, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 3, 'h33);
    checkOutput("t1_pr", cdb_prf_pr_idx, 1);
    checkOutput("t1_value", prf_pr_value, 'h11);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("t3_pr", cdb_prf_pr_idx, 3);
    checkOutput("t3_ar", cdb_ar_idx, 3);
    checkOutput("t3_value", prf_pr_value, 'h33);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("t_all_cdb", cdb_complete, 0);

    $display("[TB] hit colliding with a fill");
    applyStimulus(1, 'h6030, 30, 6, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 6, 0, 0);
    checkOutput("hf_addr", proc2mem_addr, 'h6030);
    applyStimulus(1, 'h1008, 31, 7, 0, 0, 0, 0, 6, 'h66);
    checkOutput("hf_cdb_early", cdb_complete, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("hf_hit_pr", cdb_prf_pr_idx, 31);
    checkOutput("hf_hit_value", prf_pr_value, 'h11);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("hf_fill_pr", cdb_prf_pr_idx, 30);
    checkOutput("hf_fill_ar", cdb_ar_idx, 6);
    checkOutput("hf_fill_value", prf_pr_value, 'h66);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("hf_cdb_idle", cdb_complete, 0);

    $display("[TB] store blocked by an outstanding miss");
    applyStimulus(1, 'hA8, 40, 8, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 7, 0, 0);
    checkOutput("sb_miss_addr", proc2mem_addr, 'hA8);
    applyStimulus(0, 0, 0, 0, 1, 'hA8, 'h55, 0, 0, 0);
    checkOutput("sb_ack_wait1", st_ack, 0);
    applyStimulus(0, 0, 0, 0, 1, 'hA8, 'h55, 0, 0, 0);
    checkOutput("sb_ack_wait2", st_ack, 0);
    checkOutput("sb_cmd_wait", proc2mem_command, 0);
    applyStimulus(0, 0, 0, 0, 1, 'hA8, 'h55, 0, 7, 'h77);
    checkOutput("sb_ack_fill", st_ack, 0);
    applyStimulus(0, 0, 0, 0, 1, 'hA8, 'h55, 0, 0, 0);
    checkOutput("sb_ack_done", st_ack, 0);
    checkOutput("sb_fill_pr", cdb_prf_pr_idx, 40);
    checkOutput("sb_fill_value", prf_pr_value, 'h77);
    applyStimulus(0, 0, 0, 0, 1, 'hA8, 'h55, 0, 0, 0);
    checkOutput("sb_ack", st_ack, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 9, 0, 0);
    checkOutput("sb_cmd", proc2mem_command, 2);
    checkOutput("sb_addr", proc2mem_addr, 'hA8);
    checkOutput("sb_data", proc2mem_data, 'h55);
    applyStimulus(1, 'hA8, 41, 9, 0, 0, 0, 0, 0, 0);
    checkOutput("sb_drained", proc2mem_command, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("sb_hit_pr", cdb_prf_pr_idx, 41);
    checkOutput("sb_hit_value", prf_pr_value, 'h55);

    $display("[TB] store misses and buffer retry");
    applyStimulus(0, 0, 0, 0, 1, 'hB0, 'h99, 0, 0, 0);
    checkOutput("sm_ack", st_ack, 1);
    applyStimulus(0, 0, 0, 0, 1, 'hC0, 'hAA, 0, 0, 0);
    checkOutput("sm_cmd", proc2mem_command, 2);
    checkOutput("sm_addr", proc2mem_addr, 'hB0);
    checkOutput("sm_data", proc2mem_data, 'h99);
    checkOutput("sm_ack_full", st_ack, 0);
    applyStimulus(0, 0, 0, 0, 1, 'hC0, 'hAA, 3, 0, 0);
    checkOutput("sm_retry_addr", proc2mem_addr, 'hB0);
    checkOutput("sm_ack_drain", st_ack, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 3, 0, 0);
    checkOutput("sm2_addr", proc2mem_addr, 'hC0);
    checkOutput("sm2_data", proc2mem_data, 'hAA);
    applyStimulus(1, 'hB0, 50, 10, 0, 0, 0, 0, 0, 0);
    checkOutput("sm_load_cmd", proc2mem_command, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 8, 0, 0);
    checkOutput("sm_load_miss", proc2mem_command, 1);
    checkOutput("sm_load_addr", proc2mem_addr, 'hB0);
    checkOutput("sm_load_cdb", cdb_complete, 0);

    $display("[TB] reset with misses in flight");
    applyStimulus(1, 'hD0, 51, 11, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 9, 0, 0);
    checkOutput("rm_addr", proc2mem_addr, 'hD0);
    applyStimulus(1, 'h100, 52, 12, 1, 'hE0, 1, 0, 0, 0);
    reset = 1'b0;
    #1;
    checkOutput("rm_avail", Dcache_avail, 0);
    checkOutput("rm_st_ack", st_ack, 0);
    checkOutput("rm_cmd", proc2mem_command, 0);
    checkOutput("rm_cdb", cdb_complete, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 8, 'hBAD);
    reset = 1'b1;
    #1;
    checkOutput("rm_rel_avail", Dcache_avail, 1);
    checkOutput("rm_rel_cdb", cdb_complete, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 9, 'hBAD);
    checkOutput("rm_late8_cdb", cdb_complete, 0);
    checkOutput("rm_late_cmd", proc2mem_command, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rm_late9_cdb", cdb_complete, 0);
    applyStimulus(1, 'h100, 53, 13, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rm_cold_cdb", cdb_complete, 0);
    checkOutput("rm_cold_cmd", proc2mem_command, 1);
    checkOutput("rm_cold_addr", proc2mem_addr, 'h100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
